// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// default geometry/latency and the address-width helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmemState_e;

    localparam int DMEM_DEPTH_DEFAULT = 64;
    localparam int DMEM_WAIT_DEFAULT  = 2;

    // Word-index width for a power-of-two depth; never narrower than one bit.
    function automatic int addrWidth(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the pipeline and the
// data-memory responder. MisalignedM exists only when DMEM_ALIGN_CHECK_EN
// is defined.
interface dmem_responder_if;

    logic        MemReadM;
    logic        MemWriteM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        MemStall;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        MisalignedM;

    modport master (
        output MemReadM, MemWriteM, ALUResultM, WriteDataM,
        input  ReadDataM, MemStall, MisalignedM
    );

    modport slave (
        input  MemReadM, MemWriteM, ALUResultM, WriteDataM,
        output ReadDataM, MemStall, MisalignedM
    );
`else
    modport master (
        output MemReadM, MemWriteM, ALUResultM, WriteDataM,
        input  ReadDataM, MemStall
    );

    modport slave (
        input  MemReadM, MemWriteM, ALUResultM, WriteDataM,
        output ReadDataM, MemStall
    );
`endif

endinterface

// File: rtl/dmem_array.sv
// Single-port DEPTH x 32 word storage: synchronous write, asynchronous read
// on the same address.
module dmem_array
    import dmem_pkg::*;
#(
    parameter  int DEPTH = DMEM_DEPTH_DEFAULT,
    localparam int AW    = addrWidth(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Word write on the rising edge.
    // NOTE: storage has no reset; contents are undefined until written, which keeps this a plain RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the Memory stage. Accepts one load/store at a
// time, holds MemStall for WAIT_CYCLES+1 cycles, commits the access and then
// spends one DONE cycle with the stall released. WAIT_CYCLES = 0 turns it
// into a plain single-cycle memory with a combinational read.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (adds MisalignedM).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DMEM_DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = DMEM_WAIT_DEFAULT
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);

    localparam int         AW        = addrWidth(DEPTH);
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_LOAD  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmemState_e    state, stateNext;
    logic [3:0]    cnt, cntNext;
    logic          capture, commit;

    logic [AW-1:0] capIdx;
    logic [31:0]   capData;
    logic          capWrite, capRead, capMis;
    logic [31:0]   readData;

    logic          req, reqMis;
    logic [AW-1:0] reqIdx;
    logic          unusedAddrBits;

    logic          arrayWe;
    logic [AW-1:0] arrayAddr;
    logic [31:0]   arrayWdata, arrayRdata;

    assign req            = bus.MemReadM | bus.MemWriteM;
    assign reqIdx         = bus.ALUResultM[AW+1:2];
    // Bits above the word index wrap; byte-offset bits matter only to the alignment check.
    assign unusedAddrBits = ^{bus.ALUResultM[31:AW+2], bus.ALUResultM[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign reqMis = |bus.ALUResultM[1:0];
`else
    assign reqMis = 1'b0;
`endif

    // Next-state, wait counter and stall decode for the IDLE/BUSY/DONE sequence.
    always_comb begin
        // NOTE: every signal gets a default first so no branch leaves one unassigned (no latch).
        stateNext    = state;
        cntNext      = cnt;
        capture      = 1'b0;
        commit       = 1'b0;
        bus.MemStall = 1'b0;
        case (state)
            IDLE: begin
                if (req && !ZERO_WAIT) begin
                    stateNext    = BUSY;
                    cntNext      = CNT_LOAD;
                    capture      = 1'b1;
                    bus.MemStall = 1'b1;
                end
            end
            BUSY: begin
                bus.MemStall = 1'b1;
                if (cnt != 4'd0) begin
                    cntNext = cnt - 4'd1;
                end else begin
                    commit    = 1'b1;
                    stateNext = DONE;
                end
            end
            // The request still on the bus here is the one just served.
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // FSM state and wait counter registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Request capture; DONE gating on MisalignedM makes a reset here unnecessary.
    always_ff @(posedge clk) begin
        if (capture) begin
            capIdx   <= reqIdx;
            capData  <= bus.WriteDataM;
            capWrite <= bus.MemWriteM;
            capRead  <= bus.MemReadM;
            capMis   <= reqMis;
        end
    end

    // Load data register: updated only when a read completes (old contents on read+write).
    always_ff @(posedge clk) begin
        if (reset) begin
            readData <= '0;
        end else if (commit && capRead) begin
            readData <= capMis ? '0 : arrayRdata;
        end
    end

    // A reset on the commit edge aborts the store.
    assign arrayWe    = ZERO_WAIT ? (bus.MemWriteM & ~reqMis & ~reset)
                                  : (commit & capWrite & ~capMis & ~reset);
    assign arrayAddr  = ZERO_WAIT ? reqIdx : capIdx;
    assign arrayWdata = ZERO_WAIT ? bus.WriteDataM : capData;

    dmem_array #(
        .DEPTH (DEPTH)
    ) uArray (
        .clk   (clk),
        .we    (arrayWe),
        .addr  (arrayAddr),
        .wdata (arrayWdata),
        .rdata (arrayRdata)
    );

    assign bus.ReadDataM = ZERO_WAIT ? ((reset | (req & reqMis)) ? '0 : arrayRdata)
                                     : readData;

`ifdef DMEM_ALIGN_CHECK_EN
    assign bus.MisalignedM = ZERO_WAIT ? (req & reqMis & ~reset)
                                       : ((state == DONE) & capMis);
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 instance driven through a
// scoreboard (driver pushes expected responses, monitor pops them in the
// DONE cycle) plus a WAIT_CYCLES=0 instance checked directly.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int DEPTH = 64;
    localparam int WAITN = 2;

    typedef struct {
        logic [31:0] rd;
        int          stalls;
        logic        mis;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t mon;
    logic zeroStallSeen = 1'b0;
    logic strayMis      = 1'b0;

    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAITN)) uDut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) uDutZero (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Issue one request on the multi-cycle instance and hold it through DONE.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] expRd, input logic expMis);
        exp_t e;
        @(posedge clk); #1;
        bus.MemReadM   = rd;
        bus.MemWriteM  = wr;
        bus.ALUResultM = addr;
        bus.WriteDataM = data;
        e.rd = expRd; e.stalls = WAITN + 1; e.mis = expMis; e.name = name;
        sbq.push_back(e);
        repeat (WAITN + 2) @(posedge clk);
        #1;
        bus.MemReadM  = 1'b0;
        bus.MemWriteM = 1'b0;
    endtask

    // Monitor: counts stall cycles of the live request, checks the DONE cycle.
    initial begin
        int run = 0;
        forever begin
            @(negedge clk);
            if (bus.MemReadM | bus.MemWriteM) begin
                if (bus.MemStall) begin
                    run++;
                end else if (run > 0) begin
                    if (sbq.size() == 0) begin
                        check("unexpected response", 32'd1, 32'd0);
                    end else begin
                        mon = sbq.pop_front();
                        check({mon.name, " rdata"}, bus.ReadDataM, mon.rd);
                        check({mon.name, " stall cycles"}, 32'(run), 32'(mon.stalls));
`ifdef DMEM_ALIGN_CHECK_EN
                        check({mon.name, " misaligned"}, {31'd0, bus.MisalignedM}, {31'd0, mon.mis});
`endif
                    end
                    run = 0;
                end
`ifdef DMEM_ALIGN_CHECK_EN
                if (bus.MemStall && bus.MisalignedM) strayMis = 1'b1;
`endif
            end
            if (reset) run = 0;
            if (bus0.MemStall) zeroStallSeen = 1'b1;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.MemReadM = 1'b0;  bus.MemWriteM = 1'b0;
        bus.ALUResultM = '0;  bus.WriteDataM = '0;
        bus0.MemReadM = 1'b0; bus0.MemWriteM = 1'b0;
        bus0.ALUResultM = '0; bus0.WriteDataM = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset rdata", bus.ReadDataM, 32'h0);
        check("reset stall", {31'd0, bus.MemStall}, 32'd0);

        // Basic write/read, read-before-write, wrap-around.
        access("write 0x10",      1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0);
        access("read 0x10",       1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
        access("rw 0x10",         1'b1, 1'b1, 32'h10,  32'h12345678, 32'hDEADBEEF, 1'b0);
        access("reread 0x10",     1'b1, 1'b0, 32'h10,  32'h0,        32'h12345678, 1'b0);
        access("write wrap",      1'b0, 1'b1, DEPTH*4 + 8, 32'hA5A50002, 32'h12345678, 1'b0);
        access("read 0x08",       1'b1, 1'b0, 32'h08,  32'h0,        32'hA5A50002, 1'b0);
        access("write 0x20",      1'b0, 1'b1, 32'h20,  32'h11111111, 32'hA5A50002, 1'b0);
        access("read 0x20",       1'b1, 1'b0, 32'h20,  32'h0,        32'h11111111, 1'b0);

        // Reset during the second BUSY cycle of a write aborts it.
        @(posedge clk); #1;
        bus.MemWriteM = 1'b1; bus.ALUResultM = 32'h20; bus.WriteDataM = 32'hBAD0BAD0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; bus.MemWriteM = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort stall", {31'd0, bus.MemStall}, 32'd0);
        check("abort rdata", bus.ReadDataM, 32'h0);
        access("read after abort", 1'b1, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0);

        // Reset during DONE keeps the committed write but clears ReadDataM.
        @(posedge clk); #1;
        bus.MemWriteM = 1'b1; bus.ALUResultM = 32'h30; bus.WriteDataM = 32'h33333333;
        mon.rd = 32'h11111111; mon.stalls = WAITN + 1; mon.mis = 1'b0; mon.name = "write 0x30";
        sbq.push_back(mon);
        repeat (WAITN + 1) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.MemWriteM = 1'b0;
        @(negedge clk);
        check("done-reset rdata", bus.ReadDataM, 32'h0);
        access("read 0x30", 1'b1, 1'b0, 32'h30, 32'h0, 32'h33333333, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
        access("misaligned write", 1'b0, 1'b1, 32'h13, 32'hFFFF0000, 32'h33333333, 1'b1);
        access("read after mis",   1'b1, 1'b0, 32'h10, 32'h0,        32'h12345678, 1'b0);
        access("misaligned read",  1'b1, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1);
        check("misaligned outside done", {31'd0, strayMis}, 32'd0);
`endif

        // Zero-wait instance: single-cycle writes, combinational reads.
        @(posedge clk); #1;
        bus0.MemWriteM = 1'b1; bus0.ALUResultM = 32'h0C; bus0.WriteDataM = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus0.MemWriteM = 1'b0; bus0.MemReadM = 1'b1;
        @(negedge clk);
        check("zero-wait read", bus0.ReadDataM, 32'hCAFEF00D);
        @(posedge clk); #1;
        bus0.MemWriteM = 1'b1; bus0.WriteDataM = 32'h0BADCAFE;
        @(negedge clk);
        check("zero-wait rw old data", bus0.ReadDataM, 32'hCAFEF00D);
        @(posedge clk); #1;
        bus0.MemWriteM = 1'b0;
        @(negedge clk);
        check("zero-wait rw new data", bus0.ReadDataM, 32'h0BADCAFE);
        bus0.ALUResultM = DEPTH*4 + 32'h0C;
        @(negedge clk);
        check("zero-wait wrap read", bus0.ReadDataM, 32'h0BADCAFE);
        @(posedge clk); #1;
        bus0.MemReadM = 1'b0;
        repeat (2) @(posedge clk);

        check("zero-wait never stalls", {31'd0, zeroStallSeen}, 32'd0);
        check("scoreboard drained", 32'(sbq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
